ysyx_22040729_mp_regfile: RTL and testbench

- Multi-port, parametrised integer register file for the ysyx_22040729 core.
- Next generation of the single-write, dual-read file. Adds:
  - NR read ports and NW write ports;
  - priority resolution of write collisions;
  - optional write-to-read bypass;
  - per-register busy scoreboard (set at issue, cleared at writeback);
  - synchronous clear of all state on reset.
- Sits between decode/issue (read addresses, busy set) and writeback (write ports).

---
 rtl/ysyx_22040729_rf_pkg.sv | 14 +
 rtl/ysyx_22040729_rf_wsel.sv | 33 +++
 rtl/ysyx_22040729_mp_regfile.sv | 116 +++++++++++
 tb/tb_ysyx_22040729_mp_regfile.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040729_rf_pkg.sv
// Shared defaults and helpers for the ysyx_22040729 multi-port register file.
package ysyx_22040729_rf_pkg;

  localparam int REGI_DEPTH_DEF = 32;
  localparam int DATA_WIDTH_DEF = 64;

  // Index of the hard-wired zero register.
  localparam int unsigned REG_ZERO = '0;

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/ysyx_22040729_rf_wsel.sv
// Write-port priority resolver: reports the highest-index enabled port that
// targets qaddr, together with its data and busy-clear request.
module ysyx_22040729_rf_wsel #(
  parameter int NW         = 1,
  parameter int AW         = 5,
  parameter int DATA_WIDTH = 64
) (
  input  logic [NW-1:0]            wen,
  input  logic [NW*AW-1:0]         waddr,
  input  logic [NW*DATA_WIDTH-1:0] wdata,
  input  logic [NW-1:0]            wclr,
  input  logic [AW-1:0]            qaddr,
  output logic                     hit,
  output logic [DATA_WIDTH-1:0]    data,
  output logic                     clr
);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    clr  = 1'b0;
    // Ascending scan: a later (higher-index) match overrides earlier ones.
    for (int i = 0; i < NW; i++) begin
      if (wen[i] && (waddr[i*AW +: AW] == qaddr)) begin
        hit  = 1'b1;
        data = wdata[i*DATA_WIDTH +: DATA_WIDTH];
        clr  = wclr[i];
      end
    end
  end

endmodule

// File: rtl/ysyx_22040729_mp_regfile.sv
// Multi-port integer register file with write priority, optional write-to-read
// bypass and a per-register busy scoreboard.
module ysyx_22040729_mp_regfile
  import ysyx_22040729_rf_pkg::*;
#(
  parameter  int REGI_DEPTH = REGI_DEPTH_DEF,
  parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter  int NR         = 2,
  parameter  int NW         = 1,
  parameter  int BYPASS     = 1,
  localparam int AW         = addr_w(REGI_DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NW-1:0]            wen,
  input  logic [NW*AW-1:0]         waddr,
  input  logic [NW*DATA_WIDTH-1:0] wdata,
  input  logic [NW-1:0]            wclr,
  input  logic [NR*AW-1:0]         raddr,
  output logic [NR*DATA_WIDTH-1:0] rdata,
  output logic [NR-1:0]            rbusy,
  input  logic                     set_en,
  input  logic [AW-1:0]            set_addr,
  output logic [REGI_DEPTH-1:0]    busy_vec
);

  logic [DATA_WIDTH-1:0] rf [REGI_DEPTH];
  logic [REGI_DEPTH-1:0] busy;

  // Resolved write per architectural register (register 0 never written).
  logic [REGI_DEPTH-1:1] w_hit;
  logic [REGI_DEPTH-1:1] w_clr;
  logic [DATA_WIDTH-1:0] w_data [1:REGI_DEPTH-1];

  for (genvar r = 1; r < REGI_DEPTH; r++) begin : g_wr
    ysyx_22040729_rf_wsel #(
      .NW(NW), .AW(AW), .DATA_WIDTH(DATA_WIDTH)
    ) u_wsel (
      .wen  (wen),
      .waddr(waddr),
      .wdata(wdata),
      .wclr (wclr),
      .qaddr(AW'(r)),
      .hit  (w_hit[r]),
      .data (w_data[r]),
      .clr  (w_clr[r])
    );
  end

  // NOTE: the whole array is cleared on reset, so it maps to flops, not RAM.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments only.
    rf[REG_ZERO]   <= '0;
    busy[REG_ZERO] <= 1'b0;
    if (rst) begin
      for (int r = 1; r < REGI_DEPTH; r++) rf[r] <= '0;
      busy[REGI_DEPTH-1:1] <= '0;
    end else begin
      for (int r = 1; r < REGI_DEPTH; r++) begin
        if (w_hit[r]) rf[r] <= w_data[r];
        // A fresh issue outranks a writeback clear of the same register.
        if (set_en && (set_addr == AW'(r))) busy[r] <= 1'b1;
        else if (w_hit[r] && w_clr[r])      busy[r] <= 1'b0;
      end
    end
  end

  assign busy_vec = busy;

  for (genvar p = 0; p < NR; p++) begin : g_rd
    logic [AW-1:0]         ra;
    logic [DATA_WIDTH-1:0] rd;
    logic                  rb;
    logic                  b_hit;
    logic [DATA_WIDTH-1:0] b_data;
    logic                  b_clr;

    assign ra = raddr[p*AW +: AW];

    if (BYPASS != 0) begin : g_byp
      ysyx_22040729_rf_wsel #(
        .NW(NW), .AW(AW), .DATA_WIDTH(DATA_WIDTH)
      ) u_wsel (
        .wen  (wen),
        .waddr(waddr),
        .wdata(wdata),
        .wclr (wclr),
        .qaddr(ra),
        .hit  (b_hit),
        .data (b_data),
        .clr  (b_clr)
      );
    end else begin : g_nobyp
      assign b_hit  = 1'b0;
      assign b_data = '0;
      assign b_clr  = 1'b0;
    end

    always_comb begin
      rd = '0;
      rb = 1'b0;
      if (!rst && (ra != AW'(REG_ZERO))) begin
        rd = rf[ra];
        rb = busy[ra];
        if (b_hit) begin
          rd = b_data;
          if (b_clr) rb = 1'b0;
        end
      end
    end

    assign rdata[p*DATA_WIDTH +: DATA_WIDTH] = rd;
    assign rbusy[p]                          = rb;
  end

endmodule

// File: tb/tb_ysyx_22040729_mp_regfile.sv
// Directed bench: one bypassing dual-write instance and one non-bypassing
// single-write instance, checked against hand-computed values.
module tb_ysyx_22040729_mp_regfile;

  localparam int AW = 5;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance with BYPASS=1, NW=2
  logic [1:0]      wen_b = '0;
  logic [2*AW-1:0] waddr_b = '0;
  logic [2*DW-1:0] wdata_b = '0;
  logic [1:0]      wclr_b = '0;
  logic [2*AW-1:0] raddr_b = '0;
  logic [2*DW-1:0] rdata_b;
  logic [1:0]      rbusy_b;
  logic            set_en_b = 1'b0;
  logic [AW-1:0]   set_addr_b = '0;
  logic [31:0]     busy_vec_b;

  // Instance with BYPASS=0, NW=1
  logic [0:0]      wen_n = '0;
  logic [AW-1:0]   waddr_n = '0;
  logic [DW-1:0]   wdata_n = '0;
  logic [0:0]      wclr_n = '0;
  logic [2*AW-1:0] raddr_n = '0;
  logic [2*DW-1:0] rdata_n;
  logic [1:0]      rbusy_n;
  logic            set_en_n = 1'b0;
  logic [AW-1:0]   set_addr_n = '0;
  logic [31:0]     busy_vec_n;

  int errors = 0;
  int checks = 0;

  ysyx_22040729_mp_regfile #(.NR(2), .NW(2), .BYPASS(1)) dut_b (
    .clk(clk), .rst(rst), .wen(wen_b), .waddr(waddr_b), .wdata(wdata_b),
    .wclr(wclr_b), .raddr(raddr_b), .rdata(rdata_b), .rbusy(rbusy_b),
    .set_en(set_en_b), .set_addr(set_addr_b), .busy_vec(busy_vec_b)
  );

  ysyx_22040729_mp_regfile #(.NR(2), .NW(1), .BYPASS(0)) dut_n (
    .clk(clk), .rst(rst), .wen(wen_n), .waddr(waddr_n), .wdata(wdata_n),
    .wclr(wclr_n), .raddr(raddr_n), .rdata(rdata_n), .rbusy(rbusy_n),
    .set_en(set_en_n), .set_addr(set_addr_n), .busy_vec(busy_vec_n)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wen_b = '0; wclr_b = '0; set_en_b = 1'b0;
    wen_n = '0; wclr_n = '0; set_en_n = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    raddr_b = {5'd0, 5'd5};
    raddr_n = {5'd0, 5'd5};
    tick();
    checks++; if (rdata_b !== '0) begin errors++; $display("FAIL reset_rdata_b: got %h expected 0", rdata_b); end
    checks++; if (rbusy_b !== 2'b00) begin errors++; $display("FAIL reset_rbusy_b: got %b expected 00", rbusy_b); end
    checks++; if (busy_vec_b !== 32'h0) begin errors++; $display("FAIL reset_busy_vec_b: got %h expected 0", busy_vec_b); end
    checks++; if (rdata_n !== '0) begin errors++; $display("FAIL reset_rdata_n: got %h expected 0", rdata_n); end
    checks++; if (busy_vec_n !== 32'h0) begin errors++; $display("FAIL reset_busy_vec_n: got %h expected 0", busy_vec_n); end
    rst = 1'b0;
    #1;
    checks++; if (rdata_b[DW-1:0] !== 64'h0) begin errors++; $display("FAIL post_reset_r5: got %h expected 0", rdata_b[DW-1:0]); end
  endtask

  task automatic test_write_nobypass();
    wen_n = 1'b1; waddr_n = 5'd3; wdata_n = 64'hDEAD_BEEF;
    raddr_n = {5'd0, 5'd3};
    #1;
    checks++; if (rdata_n[DW-1:0] !== 64'h0) begin errors++; $display("FAIL nobyp_same_cycle: got %h expected 0", rdata_n[DW-1:0]); end
    tick();
    idle();
    #1;
    checks++; if (rdata_n[DW-1:0] !== 64'hDEAD_BEEF) begin errors++; $display("FAIL nobyp_next_cycle: got %h expected deadbeef", rdata_n[DW-1:0]); end
  endtask

  task automatic test_bypass();
    wen_b = 2'b11; waddr_b = {5'd7, 5'd7}; wdata_b = {64'h22, 64'h11};
    raddr_b = {5'd8, 5'd7};
    #1;
    checks++; if (rdata_b[DW-1:0] !== 64'h22) begin errors++; $display("FAIL byp_collision: got %h expected 22", rdata_b[DW-1:0]); end
    checks++; if (rdata_b[2*DW-1:DW] !== 64'h0) begin errors++; $display("FAIL byp_other_port: got %h expected 0", rdata_b[2*DW-1:DW]); end
    tick();
    wen_b = 2'b01; waddr_b = {5'd0, 5'd8}; wdata_b = {64'h0, 64'h33};
    #1;
    checks++; if (rdata_b[DW-1:0] !== 64'h22) begin errors++; $display("FAIL byp_stored_r7: got %h expected 22", rdata_b[DW-1:0]); end
    checks++; if (rdata_b[2*DW-1:DW] !== 64'h33) begin errors++; $display("FAIL byp_port0_r8: got %h expected 33", rdata_b[2*DW-1:DW]); end
    tick();
    idle();
  endtask

  task automatic test_zero();
    wen_b = 2'b01; waddr_b = '0; wdata_b = {64'h0, 64'hFFFF};
    set_en_b = 1'b1; set_addr_b = 5'd0;
    raddr_b = {5'd0, 5'd0};
    #1;
    checks++; if (rdata_b !== '0) begin errors++; $display("FAIL zero_bypass: got %h expected 0", rdata_b); end
    tick();
    idle();
    #1;
    checks++; if (busy_vec_b !== 32'h0) begin errors++; $display("FAIL zero_busy_vec: got %h expected 0", busy_vec_b); end
    checks++; if ({rdata_b, rbusy_b} !== '0) begin errors++; $display("FAIL zero_read: got %h/%b expected 0/00", rdata_b, rbusy_b); end
  endtask

  task automatic test_scoreboard();
    set_en_b = 1'b1; set_addr_b = 5'd9;
    set_en_n = 1'b1; set_addr_n = 5'd9;
    raddr_b = {5'd9, 5'd9};
    raddr_n = {5'd0, 5'd9};
    #1;
    checks++; if (rbusy_b !== 2'b00) begin errors++; $display("FAIL sb_set_same_cycle: got %b expected 00", rbusy_b); end
    tick();
    idle();
    #1;
    checks++; if (busy_vec_b !== 32'h0000_0200) begin errors++; $display("FAIL sb_set_b: got %h expected 00000200", busy_vec_b); end
    checks++; if (busy_vec_n !== 32'h0000_0200) begin errors++; $display("FAIL sb_set_n: got %h expected 00000200", busy_vec_n); end
    checks++; if (rbusy_b !== 2'b11) begin errors++; $display("FAIL sb_rbusy_set: got %b expected 11", rbusy_b); end
    wen_b = 2'b10; wclr_b = 2'b10; waddr_b = {5'd9, 5'd0}; wdata_b = {64'h99, 64'h0};
    wen_n = 1'b1;  wclr_n = 1'b1;  waddr_n = 5'd9;          wdata_n = 64'h99;
    #1;
    checks++; if (rbusy_b !== 2'b00) begin errors++; $display("FAIL sb_clr_bypass: got %b expected 00", rbusy_b); end
    checks++; if (rdata_b[DW-1:0] !== 64'h99) begin errors++; $display("FAIL sb_clr_data: got %h expected 99", rdata_b[DW-1:0]); end
    checks++; if (rbusy_n[0] !== 1'b1) begin errors++; $display("FAIL sb_clr_nobyp: got %b expected 1", rbusy_n[0]); end
    tick();
    idle();
    #1;
    checks++; if (busy_vec_b !== 32'h0) begin errors++; $display("FAIL sb_cleared_b: got %h expected 0", busy_vec_b); end
    checks++; if (busy_vec_n !== 32'h0) begin errors++; $display("FAIL sb_cleared_n: got %h expected 0", busy_vec_n); end
    // wclr without wen, then a colliding write where only the lower port clears
    set_en_b = 1'b1; set_addr_b = 5'd10;
    tick();
    idle();
    wclr_b = 2'b11; waddr_b = {5'd10, 5'd10};
    tick();
    wen_b = 2'b11; wclr_b = 2'b01; wdata_b = {64'hA1, 64'hA0};
    raddr_b = {5'd10, 5'd10};
    #1;
    checks++; if (rbusy_b !== 2'b11) begin errors++; $display("FAIL sb_collision_rbusy: got %b expected 11", rbusy_b); end
    tick();
    idle();
    #1;
    checks++; if (busy_vec_b !== 32'h0000_0400) begin errors++; $display("FAIL sb_collision_hold: got %h expected 00000400", busy_vec_b); end
    checks++; if (rdata_b[DW-1:0] !== 64'hA1) begin errors++; $display("FAIL sb_collision_data: got %h expected a1", rdata_b[DW-1:0]); end
    wen_b = 2'b01; wclr_b = 2'b01; waddr_b = {5'd0, 5'd10};
    tick();
    idle();
  endtask

  task automatic test_set_clear_rst();
    set_en_b = 1'b1; set_addr_b = 5'd4;
    wen_b = 2'b01; wclr_b = 2'b01; waddr_b = {5'd0, 5'd4}; wdata_b = {64'h0, 64'h44};
    tick();
    idle();
    raddr_b = {5'd0, 5'd4};
    #1;
    checks++; if (busy_vec_b !== 32'h0000_0010) begin errors++; $display("FAIL setclr_busy: got %h expected 00000010", busy_vec_b); end
    checks++; if (rdata_b[DW-1:0] !== 64'h44) begin errors++; $display("FAIL setclr_data: got %h expected 44", rdata_b[DW-1:0]); end
    rst = 1'b1;
    wen_b = 2'b01; waddr_b = {5'd0, 5'd4}; wdata_b = {64'h0, 64'h55};
    set_en_b = 1'b1; set_addr_b = 5'd6;
    tick();
    rst = 1'b0;
    idle();
    #1;
    checks++; if (busy_vec_b !== 32'h0) begin errors++; $display("FAIL rst_mid_busy: got %h expected 0", busy_vec_b); end
    checks++; if (rdata_b[DW-1:0] !== 64'h0) begin errors++; $display("FAIL rst_mid_r4: got %h expected 0", rdata_b[DW-1:0]); end
    raddr_n = {5'd0, 5'd3};
    #1;
    checks++; if (rdata_n[DW-1:0] !== 64'h0) begin errors++; $display("FAIL rst_mid_r3_n: got %h expected 0", rdata_n[DW-1:0]); end
  endtask

  initial begin
    test_reset();
    test_write_nobypass();
    test_bypass();
    test_zero();
    test_scoreboard();
    test_set_clear_rst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
